read32_stream_arbiter: RTL and testbench



---
 rtl/read32_stream_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_read32_stream_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read32_stream_arbiter.sv
// Round-robin burst arbiter feeding /dev/xillybus_read_32 from NUM_SRC standard FIFOs.
// Define STREAM_TRAILER_EN to append a {A5, grant, word count} trailer word after every burst.
module read32_stream_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BURST = 64,
    parameter int OUT_DEPTH = 8
) (
    input  logic                   bus_clk,
    input  logic                   bus_rst_n,
    input  logic [NUM_SRC-1:0]     src_enable,
    input  logic [NUM_SRC-1:0]     src_empty,
    output logic [NUM_SRC-1:0]     src_rd_en,
    input  logic [32*NUM_SRC-1:0]  src_data,
    input  logic                   user_r_read_32_rden,
    output logic                   user_r_read_32_empty,
    output logic [31:0]            user_r_read_32_data,
    output logic                   user_r_read_32_eof,
    input  logic                   user_r_read_32_open,
    output logic                   busy
);

    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   MAX_WC  = 16'(MAX_BURST);
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
`ifdef STREAM_TRAILER_EN
        S_TRAIL,
`endif
        S_DONE
    } state_t;

    state_t         state;
    logic [SW-1:0]  grant;
    logic [SW-1:0]  rr_ptr;
    logic [15:0]    wc;
    logic           inflight;
    logic [31:0]    mem [OUT_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic [31:0]    src_word [NUM_SRC];
    logic [NUM_SRC-1:0] eligible;
    logic           any_elig;
    logic [SW-1:0]  next_grant;
    logic           src_ok;
    logic           room;
    logic           can_read;
    logic           burst_end;
    logic           wr_en;
    logic [31:0]    wr_data;
    logic           rd_fire;

    assign eligible = src_enable & ~src_empty;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        any_elig   = 1'b0;
        next_grant = '0;
        // Walk from the farthest candidate back to rr_ptr so the nearest eligible source wins.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (eligible[SW'((int'(rr_ptr) + k) % NUM_SRC)]) begin
                any_elig   = 1'b1;
                next_grant = SW'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_word[i] = src_data[32*i +: 32];
        end
    end

    assign src_ok    = src_enable[grant] && !src_empty[grant] && (wc < MAX_WC);
    assign room      = (count + CW'(inflight)) < DEPTH_C;
    assign burst_end = (state == S_XFER) && !src_ok;

    // NOTE: the read strobe is decoded from registered state and the live empty flag; registering it
    // would act on a stale empty and could read past the end of a source FIFO.
    assign can_read = (state == S_XFER) && user_r_read_32_open && src_ok && room;

    always_comb begin
        src_rd_en = '0;
        if (can_read) src_rd_en[grant] = 1'b1;
    end

`ifdef STREAM_TRAILER_EN
    logic        trl_wr;
    logic [2:0]  grant3;
    assign grant3  = 3'(grant);
    assign trl_wr  = (state == S_TRAIL) && !inflight && (count != DEPTH_C);
    assign wr_en   = inflight || trl_wr;
    assign wr_data = inflight ? src_word[grant] : {8'hA5, 5'b0, grant3, wc};
`else
    assign wr_en   = inflight;
    assign wr_data = src_word[grant];
`endif

    assign rd_fire              = user_r_read_32_rden && (count != '0);
    assign user_r_read_32_empty = (count == '0);
    assign user_r_read_32_eof   = 1'b0;

    // NOTE: the storage array is deliberately not reset; count and the pointers define which entries are valid.
    always_ff @(posedge bus_clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state               <= S_IDLE;
            grant               <= '0;
            rr_ptr              <= '0;
            wc                  <= '0;
            inflight            <= 1'b0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            busy                <= 1'b0;
            user_r_read_32_data <= '0;
        end else if (!user_r_read_32_open) begin
            // Closing the file flushes everything, including a word still on its way from a source.
            state    <= S_IDLE;
            rr_ptr   <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            busy     <= 1'b0;
        end else begin
            inflight <= can_read;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) begin
                rd_ptr              <= rd_ptr + AW'(1);
                user_r_read_32_data <= mem[rd_ptr];
            end
            unique case ({wr_en, rd_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            unique case (state)
                S_IDLE: begin
                    if (any_elig) begin
                        grant <= next_grant;
                        wc    <= '0;
                        busy  <= 1'b1;
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    // A full output FIFO only stalls here; the burst ends on source empty/disable or length.
                    if (can_read) begin
                        wc <= wc + 16'd1;
                    end else if (burst_end) begin
`ifdef STREAM_TRAILER_EN
                        state <= S_TRAIL;
`else
                        state <= S_DONE;
`endif
                    end
                end
`ifdef STREAM_TRAILER_EN
                S_TRAIL: begin
                    if (trl_wr) state <= S_DONE;
                end
`endif
                S_DONE: begin
                    rr_ptr <= (grant == SW'(NUM_SRC - 1)) ? '0 : grant + SW'(1);
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read32_stream_arbiter.sv
// Directed bench for read32_stream_arbiter: behavioural source FIFOs, a continuous core reader and
// hand-built expected word lists (trailer words included when STREAM_TRAILER_EN is defined).
`timescale 1ns/1ps
module tb_read32_stream_arbiter;

    localparam int TRL = `ifdef STREAM_TRAILER_EN 1 `else 0 `endif;

    logic         bus_clk = 1'b0;
    logic         bus_rst_n;
    logic [3:0]   src_enable;
    logic [3:0]   src_empty = 4'hF;
    logic [3:0]   src_rd_en;
    logic [127:0] src_data;
    logic         user_r_read_32_rden;
    logic         user_r_read_32_empty;
    logic [31:0]  user_r_read_32_data;
    logic         user_r_read_32_eof;
    logic         user_r_read_32_open;
    logic         busy;

    logic [31:0]  src_q [4][$];
    logic [31:0]  src_dout [4];
    logic [31:0]  exp_q [$];
    int           checks = 0;
    int           errors = 0;

    read32_stream_arbiter #(.NUM_SRC(4), .MAX_BURST(64), .OUT_DEPTH(8)) dut (
        .bus_clk              (bus_clk),
        .bus_rst_n            (bus_rst_n),
        .src_enable           (src_enable),
        .src_empty            (src_empty),
        .src_rd_en            (src_rd_en),
        .src_data             (src_data),
        .user_r_read_32_rden  (user_r_read_32_rden),
        .user_r_read_32_empty (user_r_read_32_empty),
        .user_r_read_32_data  (user_r_read_32_data),
        .user_r_read_32_eof   (user_r_read_32_eof),
        .user_r_read_32_open  (user_r_read_32_open),
        .busy                 (busy)
    );

    always #5 bus_clk = ~bus_clk;

    assign src_data = {src_dout[3], src_dout[2], src_dout[1], src_dout[0]};

    // Standard-FIFO source models: dout updates on the edge that samples rd_en.
    always @(posedge bus_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (src_rd_en[i]) begin
                if (src_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL src%0d_underflow: got read strobe, required none (source empty)", i);
                end else begin
                    src_dout[i] <= src_q[i].pop_front();
                end
            end
            src_empty[i] <= (src_q[i].size() == 0);
        end
    end

    task automatic load_src(input int s, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) src_q[s].push_back(base + 32'(k));
    endtask

    task automatic exp_words(input logic [31:0] base, input int first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(base + 32'(first + k));
    endtask

    task automatic exp_trailer(input int g, input int wc);
        logic [31:0] w;
        w = {8'hA5, 5'b0, 3'(g), 16'(wc)};
        if (TRL != 0) exp_q.push_back(w);
    endtask

    // Reads every expected word with rden held whenever the FIFO is non-empty.
    task automatic drain(input string name);
        int n;
        int got;
        int cyc;
        logic pend;
        logic [31:0] exp;
        n = exp_q.size();
        got = 0;
        cyc = 0;
        pend = 1'b0;
        while (got < n && cyc < 4000) begin
            @(negedge bus_clk);
            cyc++;
            if (pend) begin
                exp = exp_q.pop_front();
                checks++;
                if (user_r_read_32_data !== exp) begin
                    errors++;
                    $display("FAIL %s word %0d: got %h required %h", name, got, user_r_read_32_data, exp);
                end
                got++;
            end
            pend = (got < n) && !user_r_read_32_empty;
            user_r_read_32_rden = pend;
        end
        user_r_read_32_rden = 1'b0;
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d words required %0d", name, got, n);
            exp_q.delete();
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        @(negedge bus_clk);
        while (busy && cyc < 200) begin
            @(negedge bus_clk);
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy got %b required 0", name, busy);
        end
    endtask

    task automatic reopen();
        @(negedge bus_clk);
        user_r_read_32_open = 1'b0;
        @(negedge bus_clk);
        user_r_read_32_open = 1'b1;
    endtask

    // Returns once the given source's strobe has been seen n times; the caller acts on the next negedge.
    task automatic count_strobes(input int s, input int n, input string name);
        int seen;
        int cyc;
        seen = 0;
        cyc = 0;
        while (seen < n && cyc < 200) begin
            @(negedge bus_clk);
            cyc++;
            if (src_rd_en[s]) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL %s strobes: got %0d required %0d", name, seen, n);
        end
        @(negedge bus_clk);
    endtask

    task automatic test_reset();
        checks++; if (src_rd_en !== 4'b0) begin errors++; $display("FAIL reset_rd_en: got %b required 0000", src_rd_en); end
        checks++; if (user_r_read_32_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b required 1", user_r_read_32_empty); end
        checks++; if (user_r_read_32_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", user_r_read_32_data); end
        checks++; if (user_r_read_32_eof !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b required 0", user_r_read_32_eof); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_single();
        @(negedge bus_clk);
        load_src(1, 32'h11, 3);
        exp_q.push_back(32'h11); exp_q.push_back(32'h12); exp_q.push_back(32'h13);
        if (TRL != 0) exp_q.push_back(32'hA501_0003);
        drain("single");
        wait_idle("single");
        // rr_ptr is now 2, so src2 must win over src1 when both become ready together.
        @(negedge bus_clk);
        load_src(1, 32'h21, 1);
        load_src(2, 32'h31, 1);
        exp_words(32'h31, 0, 1); exp_trailer(2, 1);
        exp_words(32'h21, 0, 1); exp_trailer(1, 1);
        drain("rr_ptr");
        wait_idle("rr_ptr");
    endtask

    task automatic test_round_robin();
        reopen();
        @(negedge bus_clk);
        load_src(0, 32'h0A00_0000, 100);
        load_src(2, 32'h0C00_0000, 100);
        exp_words(32'h0A00_0000, 0, 64);  exp_trailer(0, 64);
        exp_words(32'h0C00_0000, 0, 64);  exp_trailer(2, 64);
        exp_words(32'h0A00_0000, 64, 36); exp_trailer(0, 36);
        exp_words(32'h0C00_0000, 64, 36); exp_trailer(2, 36);
        drain("round_robin");
        wait_idle("round_robin");
    endtask

    task automatic test_backpressure();
        logic strobed;
        reopen();
        @(negedge bus_clk);
        load_src(3, 32'h3300_0000, 20);
        repeat (40) @(negedge bus_clk);
        checks++; if (src_q[3].size() != 12) begin errors++; $display("FAIL bp_buffered: got %0d source words left required 12", src_q[3].size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b required 1", busy); end
        checks++; if (user_r_read_32_empty !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b required 0", user_r_read_32_empty); end
        strobed = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge bus_clk);
            if (src_rd_en !== 4'b0) strobed = 1'b1;
        end
        checks++; if (strobed !== 1'b0) begin errors++; $display("FAIL bp_stall: got strobe %b required 0", strobed); end
        exp_words(32'h3300_0000, 0, 20); exp_trailer(3, 20);
        drain("backpressure");
        wait_idle("backpressure");
    endtask

    task automatic test_disable();
        reopen();
        @(negedge bus_clk);
        load_src(0, 32'h4400_0000, 10);
        count_strobes(0, 5, "disable");
        src_enable[0] = 1'b0;
        repeat (20) @(negedge bus_clk);
        checks++; if (src_q[0].size() != 5) begin errors++; $display("FAIL disable_reads: got %0d source words left required 5", src_q[0].size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL disable_busy: got %b required 0", busy); end
        exp_words(32'h4400_0000, 0, 5);
        if (TRL != 0) exp_q.push_back(32'hA500_0005);
        drain("disable");
        src_q[0].delete();
        src_enable[0] = 1'b1;
        wait_idle("disable");
    endtask

    task automatic test_close();
        reopen();
        @(negedge bus_clk);
        load_src(1, 32'h5500_0000, 20);
        count_strobes(1, 5, "close");
        user_r_read_32_open = 1'b0;
        @(negedge bus_clk);
        checks++; if (user_r_read_32_empty !== 1'b1) begin errors++; $display("FAIL close_empty: got %b required 1", user_r_read_32_empty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL close_busy: got %b required 0", busy); end
        checks++; if (src_rd_en !== 4'b0) begin errors++; $display("FAIL close_rd_en: got %b required 0000", src_rd_en); end
        checks++; if (src_q[1].size() != 15) begin errors++; $display("FAIL close_src_left: got %0d required 15", src_q[1].size()); end
        user_r_read_32_open = 1'b1;
        exp_words(32'h5500_0000, 5, 15); exp_trailer(1, 15);
        drain("reopen");
        wait_idle("reopen");
    endtask

    task automatic test_async_reset();
        @(negedge bus_clk);
        load_src(2, 32'h6600_0000, 10);
        count_strobes(2, 3, "arst");
        checks++; if (user_r_read_32_empty !== 1'b0) begin errors++; $display("FAIL arst_pre_empty: got %b required 0", user_r_read_32_empty); end
        #2 bus_rst_n = 1'b0;
        #1;
        checks++; if (src_rd_en !== 4'b0) begin errors++; $display("FAIL arst_rd_en: got %b required 0000", src_rd_en); end
        checks++; if (user_r_read_32_empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b required 1", user_r_read_32_empty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b required 0", busy); end
        checks++; if (user_r_read_32_data !== 32'h0) begin errors++; $display("FAIL arst_data: got %h required 0", user_r_read_32_data); end
        src_q[2].delete();
        repeat (2) @(negedge bus_clk);
        bus_rst_n = 1'b1;
        @(negedge bus_clk);
        load_src(2, 32'hBEEF_0001, 1);
        exp_words(32'hBEEF_0001, 0, 1); exp_trailer(2, 1);
        drain("post_reset");
        wait_idle("post_reset");
    endtask

    initial begin
        bus_rst_n           = 1'b0;
        src_enable          = 4'h0;
        user_r_read_32_rden = 1'b0;
        user_r_read_32_open = 1'b0;
        for (int i = 0; i < 4; i++) src_dout[i] = 32'h0;
        repeat (3) @(negedge bus_clk);
        test_reset();
        bus_rst_n           = 1'b1;
        src_enable          = 4'hF;
        user_r_read_32_open = 1'b1;
        test_single();
        test_round_robin();
        test_backpressure();
        test_disable();
        test_close();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
